// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int REG_W          = 5;
    localparam int CNT_W          = 16;
    localparam int FRZ_W          = 8;
    localparam int FREEZE_TIMEOUT = 255;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FREEZE   = 2'd2
    } hz_state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; stats outputs exist only with HAZARD_STATS_EN.
interface hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rt;
    logic             branch_taken;
    logic             mem_busy;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             pipe_freeze;
    logic [1:0]       state_out;
    logic             timeout_err;
`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] freeze_cnt;
`endif

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
`ifdef HAZARD_STATS_EN
        input  stall_cnt, flush_cnt, freeze_cnt,
`endif
        input  pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
               state_out, timeout_err
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rt, branch_taken, mem_busy,
`ifdef HAZARD_STATS_EN
        output stall_cnt, flush_cnt, freeze_cnt,
`endif
        output pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze,
               state_out, timeout_err
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + WIDTH'(1);
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch / memory-wait hazard controller with freeze watchdog.
// Optional event counters are built when HAZARD_STATS_EN is defined.
module hazard_ctrl
    import pipe_ctrl_pkg::*;
(
    input logic          clk,
    input logic          rst,
    hazard_ctrl_if.slave hc
);

    hz_state_t        state_q, state_d;
    logic             hz;
    logic             pc_write_d, if_id_write_d, if_id_flush_d, id_ex_bubble_d, pipe_freeze_d;
    logic [FRZ_W-1:0] frz_cnt;
    logic             frz_at_limit;
    logic             timeout_q;

    assign hz = hc.ex_mem_read && (hc.ex_rt != '0) &&
                ((hc.ex_rt == hc.id_rs) || (hc.id_uses_rt && (hc.ex_rt == hc.id_rt)));

    // LU_STALL ignores hz so one load can never cause two stall cycles in a row.
    always_comb begin
        pc_write_d     = 1'b1;
        if_id_write_d  = 1'b1;
        if_id_flush_d  = 1'b0;
        id_ex_bubble_d = 1'b0;
        pipe_freeze_d  = 1'b0;
        state_d        = RUN;
        if (rst) begin
            pc_write_d     = 1'b0;
            if_id_write_d  = 1'b0;
            if_id_flush_d  = 1'b1;
            id_ex_bubble_d = 1'b1;
        end else if (hc.mem_busy) begin
            pc_write_d    = 1'b0;
            if_id_write_d = 1'b0;
            pipe_freeze_d = 1'b1;
            state_d       = FREEZE;
        end else if (hz && (state_q != LU_STALL)) begin
            pc_write_d     = 1'b0;
            if_id_write_d  = 1'b0;
            id_ex_bubble_d = 1'b1;
            state_d        = LU_STALL;
        end else if (hc.branch_taken) begin
            if_id_flush_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    sat_counter #(.WIDTH(FRZ_W)) u_frz_cnt (
        .clk     (clk),
        .inc     (hc.mem_busy),
        .clr     (rst || !hc.mem_busy),
        .count_o (frz_cnt)
    );

    assign frz_at_limit = (frz_cnt == FRZ_W'(FREEZE_TIMEOUT));

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_q <= 1'b0;
        end else if (frz_at_limit) begin
            timeout_q <= 1'b1;
        end
    end

    assign hc.pc_write     = pc_write_d;
    assign hc.if_id_write  = if_id_write_d;
    assign hc.if_id_flush  = if_id_flush_d;
    assign hc.id_ex_bubble = id_ex_bubble_d;
    assign hc.pipe_freeze  = pipe_freeze_d;
    assign hc.state_out    = state_q;
    assign hc.timeout_err  = !rst && (timeout_q || frz_at_limit);

`ifdef HAZARD_STATS_EN
    logic [2:0]       stat_inc;
    logic [CNT_W-1:0] stat_cnt [3];

    assign stat_inc = {pipe_freeze_d, if_id_flush_d, id_ex_bubble_d} & {3{!rst}};

    for (genvar gi = 0; gi < 3; gi++) begin : g_stats
        sat_counter #(.WIDTH(CNT_W)) u_stat_cnt (
            .clk     (clk),
            .inc     (stat_inc[gi]),
            .clr     (rst),
            .count_o (stat_cnt[gi])
        );
    end

    assign hc.stall_cnt  = stat_cnt[0];
    assign hc.flush_cnt  = stat_cnt[1];
    assign hc.freeze_cnt = stat_cnt[2];
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus random traffic vs a reference model.
module tb_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_ctrl_if hc ();

    hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .hc  (hc.slave)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int m_state = 0;
    bit m_known = 1'b0;
    int m_busy_run = 0;
    bit m_tripped = 1'b0;
    int m_stall = 0;
    int m_flush = 0;
    int m_freeze = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit r, input logic [4:0] rs, input logic [4:0] rt, input bit ut,
                        input bit mr, input logic [4:0] ert, input bit br, input bit mb);
        bit hz;
        bit e_pc, e_ifw, e_fl, e_bub, e_frz;
        int nxt;
        @(negedge clk);
        rst             = r;
        hc.id_rs        = rs;
        hc.id_rt        = rt;
        hc.id_uses_rt   = ut;
        hc.ex_mem_read  = mr;
        hc.ex_rt        = ert;
        hc.branch_taken = br;
        hc.mem_busy     = mb;
        #1;
        hz = mr && (ert != 0) && ((ert == rs) || (ut && (ert == rt)));
        e_pc = 1; e_ifw = 1; e_fl = 0; e_bub = 0; e_frz = 0; nxt = 0;
        if (r) begin
            e_pc = 0; e_ifw = 0; e_fl = 1; e_bub = 1;
        end else if (mb) begin
            e_pc = 0; e_ifw = 0; e_frz = 1; nxt = 2;
        end else if (hz && m_state != 1) begin
            e_pc = 0; e_ifw = 0; e_bub = 1; nxt = 1;
        end else begin
            e_fl = br;
        end
        chk("pc_write", hc.pc_write, e_pc);
        chk("if_id_write", hc.if_id_write, e_ifw);
        chk("if_id_flush", hc.if_id_flush, e_fl);
        chk("id_ex_bubble", hc.id_ex_bubble, e_bub);
        chk("pipe_freeze", hc.pipe_freeze, e_frz);
        chk("timeout_err", hc.timeout_err, r ? 1'b0 : m_tripped);
        if (m_known) begin
            chk("state_out", hc.state_out, m_state);
`ifdef HAZARD_STATS_EN
            chk("stall_cnt", hc.stall_cnt, m_stall);
            chk("flush_cnt", hc.flush_cnt, m_flush);
            chk("freeze_cnt", hc.freeze_cnt, m_freeze);
`endif
        end
        if (r) begin
            m_busy_run = 0; m_tripped = 0;
            m_stall = 0; m_flush = 0; m_freeze = 0;
            m_known = 1'b1;
        end else begin
            m_busy_run = mb ? m_busy_run + 1 : 0;
            if (m_busy_run >= 255) m_tripped = 1'b1;
            if (e_bub && m_stall < 65535) m_stall++;
            if (e_fl && m_flush < 65535) m_flush++;
            if (e_frz && m_freeze < 65535) m_freeze++;
        end
        m_state = nxt;
    endtask

    task automatic idle();
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
    endtask

    initial begin
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
        idle();
        chk("post_reset_state", hc.state_out, 2'd0);

        // Load-use on rs, then LU_STALL with normal outputs
        step(0, 5'd8, 5'd1, 0, 1, 5'd8, 0, 0);
        chk("lu_rs_c0_bubble", hc.id_ex_bubble, 1'b1);
        chk("lu_rs_c0_pc", hc.pc_write, 1'b0);
        step(0, 5'd8, 5'd1, 0, 1, 5'd8, 0, 0);
        chk("lu_rs_c1_state", hc.state_out, 2'd1);
        chk("lu_rs_c1_pc", hc.pc_write, 1'b1);
        chk("lu_rs_c1_bubble", hc.id_ex_bubble, 1'b0);

        // Register zero never stalls
        step(0, 5'd0, 5'd0, 0, 1, 5'd0, 0, 0);
        chk("r0_pc", hc.pc_write, 1'b1);

        // rt gating
        step(0, 5'd3, 5'd9, 0, 1, 5'd9, 0, 0);
        chk("rt_gated_off", hc.id_ex_bubble, 1'b0);
        step(0, 5'd3, 5'd9, 1, 1, 5'd9, 0, 0);
        chk("rt_gated_on", hc.id_ex_bubble, 1'b1);
        idle();

        // Branch collides with hz: flush deferred one cycle, only one cycle
        step(0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 0);
        chk("br_hz_c0_flush", hc.if_id_flush, 1'b0);
        step(0, 5'd8, 5'd0, 0, 1, 5'd8, 1, 0);
        chk("br_hz_c1_flush", hc.if_id_flush, 1'b1);
        idle();
        chk("br_hz_c2_flush", hc.if_id_flush, 1'b0);

        // mem_busy over hz for 3 cycles, then the stall
        for (int i = 0; i < 3; i++) begin
            step(0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 1);
            chk("busy_hz_freeze", hc.pipe_freeze, 1'b1);
        end
        step(0, 5'd8, 5'd0, 0, 1, 5'd8, 0, 0);
        chk("busy_hz_then_stall", hc.id_ex_bubble, 1'b1);
        idle();

        // Reset mid-LU_STALL aborts to RUN
        step(0, 5'd4, 5'd0, 0, 1, 5'd4, 0, 0);
        step(1, 5'd4, 5'd0, 0, 1, 5'd4, 0, 0);
        step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
        chk("rst_abort_state", hc.state_out, 2'd0);

        // Watchdog
        for (int i = 0; i < 256; i++) step(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1);
        chk("wdog_set", hc.timeout_err, 1'b1);
        for (int i = 0; i < 4; i++) idle();
        chk("wdog_sticky", hc.timeout_err, 1'b1);
        step(1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0);
        idle();
        chk("wdog_cleared", hc.timeout_err, 1'b0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 59) == 0,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 2) != 0, 5'($urandom_range(0, 3)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
